// File: rtl/ssc_pkg.sv
// ============================================================================
// Module   : ssc_pkg
// Purpose  : Shared state encoding and default constants for ssc_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  localparam int unsigned c_DIV     = 100_000_000;
  localparam logic [3:0]  c_RST_PAT = 4'b1011;

endpackage

`default_nettype wire

// File: rtl/ssc_tick_gen.sv
// ============================================================================
// Module   : ssc_tick_gen
// Purpose  : Free-running 0..DIV-1 divider with enable and synchronous clear.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssc_tick_gen
  import ssc_pkg::*;
#(
  parameter int unsigned DIV = c_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned     c_CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV - 1);

  logic [c_CW-1:0] cnt_q;
  logic [c_CW-1:0] cnt_d;
  logic            w_last;

  assign w_last = (cnt_q == c_LAST);
  assign tick_o = en_i & w_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = w_last ? '0 : cnt_q + c_CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssc_seq_ctrl.sv
// ============================================================================
// Module   : ssc_seq_ctrl
// Purpose  : Serial sequence checker controller: sampling, window match, count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssc_seq_ctrl
  import ssc_pkg::*;
#(
  parameter int unsigned      DIV     = c_DIV,
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(c_RST_PAT)
) (
  input  logic             clk_main,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  output logic             cfg_ready,
  input  logic             data_in,
  output logic             sample_tick,
  output logic [PAT_W-1:0] out_light,
  output logic             success_light,
  output logic [CNT_W-1:0] match_count,
  output logic             busy
);

  localparam int unsigned      c_FW      = $clog2(PAT_W + 1);
  localparam logic [c_FW-1:0]  c_FULL    = c_FW'(PAT_W);
  localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [PAT_W-1:0] win_q, win_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic             succ_q, succ_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [c_FW-1:0]  fill_q, fill_d;

  logic             w_tick;
  logic             w_idle;
  logic             w_full;
  logic [PAT_W-1:0] w_win_shift;
  logic [c_FW-1:0]  w_fill_inc;

  assign w_idle = (state_q == IDLE);

  ssc_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk_main),
    .rst    (rst),
    .en_i   (~w_idle),
    .clr_i  (w_idle),
    .tick_o (w_tick)
  );

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    pat_d       = pat_q;
    ovl_d       = ovl_q;
    succ_d      = succ_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    w_win_shift = {win_q[PAT_W-2:0], data_in};
    w_fill_inc  = fill_q + c_FW'(1);
    w_full      = 1'b0;

    if (w_idle && cfg_valid) begin
      pat_d = cfg_pattern;
      ovl_d = cfg_overlap;
    end

    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          state_d = FILL;
          win_d   = '0;
          cnt_d   = '0;
          succ_d  = 1'b0;
          fill_d  = '0;
        end
      end
      FILL, RUN: begin
        // stop takes priority over a coincident tick: no shift, no match
        if (stop) begin
          state_d = IDLE;
          succ_d  = 1'b0;
        end else if (w_tick) begin
          win_d  = w_win_shift;
          succ_d = 1'b0;
          w_full = (state_q == RUN) || (w_fill_inc == c_FULL);
          if (state_q == FILL) begin
            fill_d = w_fill_inc;
          end
          if (w_full) begin
            state_d = RUN;
            if (w_win_shift == pat_q) begin
              succ_d = 1'b1;
              if (cnt_q != c_CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
              end
              // non-overlapping: keep the window but demand PAT_W fresh samples
              if (!ovl_q) begin
                state_d = FILL;
                fill_d  = '0;
              end
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      pat_q   <= RST_PAT;
      ovl_q   <= 1'b1;
      succ_q  <= 1'b0;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      succ_q  <= succ_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  assign cfg_ready     = w_idle;
  assign busy          = ~w_idle;
  assign sample_tick   = w_tick;
  assign out_light     = win_q;
  assign success_light = succ_q;
  assign match_count   = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ssc_seq_ctrl.sv
// ============================================================================
// Module   : tb_ssc_seq_ctrl
// Purpose  : Scoreboard bench for ssc_seq_ctrl (DIV=4; CNT_W=8 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssc_seq_ctrl;

  localparam int DIV = 4;

  logic       clk_main = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [3:0] cfg_pattern = 4'd0;
  logic       cfg_overlap = 1'b0;
  logic       data_in = 1'b0;

  logic       cfg_ready, sample_tick, success_light, busy;
  logic [3:0] out_light;
  logic [7:0] match_count;
  logic       s_cfg_ready, s_sample_tick, s_success_light, s_busy;
  logic [3:0] s_out_light;
  logic [1:0] s_match_count;

  always #5 clk_main = ~clk_main;

  ssc_seq_ctrl #(.DIV(DIV), .PAT_W(4), .CNT_W(8), .RST_PAT(4'b1011)) dut (
    .clk_main(clk_main), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cfg_ready(cfg_ready), .data_in(data_in), .sample_tick(sample_tick),
    .out_light(out_light), .success_light(success_light),
    .match_count(match_count), .busy(busy)
  );

  ssc_seq_ctrl #(.DIV(DIV), .PAT_W(4), .CNT_W(2), .RST_PAT(4'b1011)) dut_sat (
    .clk_main(clk_main), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .cfg_ready(s_cfg_ready), .data_in(data_in), .sample_tick(s_sample_tick),
    .out_light(s_out_light), .success_light(s_success_light),
    .match_count(s_match_count), .busy(s_busy)
  );

  typedef struct {
    logic [3:0] win;
    logic       succ;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  // reference state of the sequence checker
  logic [3:0] m_win;
  logic [3:0] m_pat;
  logic       m_ovl;
  logic       m_succ;
  int         m_fill;
  int         m_cnt;
  int         m_cnt_s;

  task automatic model_start();
    m_win = 4'd0; m_fill = 0; m_cnt = 0; m_cnt_s = 0; m_succ = 1'b0;
  endtask

  task automatic model_sample(input logic d);
    m_win  = {m_win[2:0], d};
    m_fill = m_fill + 1;
    m_succ = 1'b0;
    if (m_fill >= 4 && m_win == m_pat) begin
      m_succ = 1'b1;
      if (m_cnt < 255) m_cnt = m_cnt + 1;
      if (m_cnt_s < 3) m_cnt_s = m_cnt_s + 1;
      if (!m_ovl) m_fill = 0;
    end
  endtask

  // drive one serial sample, wait for its tick, push expectation, pop and check
  task automatic do_sample(input logic d, input int exp_n);
    int   n;
    bit   stable;
    exp_t e;
    data_in = d;
    n = 0;
    stable = 1'b1;
    while (sample_tick !== 1'b1 && n < 50) begin
      if (success_light !== m_succ) stable = 1'b0;
      @(negedge clk_main);
      n++;
    end
    if (success_light !== m_succ) stable = 1'b0;
    n_cmp++;
    if (sample_tick !== 1'b1 || n != exp_n) begin
      n_bad++;
      $display("FAIL tick_period: waited %0d cycles, required %0d", n, exp_n);
    end
    n_cmp++;
    if (!stable) begin
      n_bad++;
      $display("FAIL succ_hold: success_light changed between ticks, required %0b", m_succ);
    end
    model_sample(d);
    sb.push_back('{win: m_win, succ: m_succ, cnt: 8'(m_cnt), cnt_s: 2'(m_cnt_s)});
    @(negedge clk_main);
    e = sb.pop_front();
    n_cmp++;
    if (out_light !== e.win || success_light !== e.succ ||
        match_count !== e.cnt || s_match_count !== e.cnt_s) begin
      n_bad++;
      $display("FAIL sample: got win=%b succ=%b cnt=%0d cnt_s=%0d, required win=%b succ=%b cnt=%0d cnt_s=%0d",
               out_light, success_light, match_count, s_match_count,
               e.win, e.succ, e.cnt, e.cnt_s);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk_main);
    start = 1'b0;
    model_start();
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk_main);
    stop = 1'b0;
    m_succ = 1'b0;
  endtask

  task automatic test_reset();
    int ticks;
    rst = 1'b1;
    repeat (2) @(negedge clk_main);
    rst = 1'b0;
    n_cmp++;
    if (out_light !== 4'd0 || success_light !== 1'b0 || match_count !== 8'd0 ||
        sample_tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset: got win=%b succ=%b cnt=%0d tick=%b busy=%b rdy=%b, required 0000 0 0 0 0 1",
               out_light, success_light, match_count, sample_tick, busy, cfg_ready);
    end
    ticks = 0;
    repeat (20) begin
      @(negedge clk_main);
      if (sample_tick !== 1'b0) ticks++;
    end
    n_cmp++;
    if (ticks != 0) begin
      n_bad++;
      $display("FAIL idle_tick: got %0d ticks, required 0", ticks);
    end
    m_pat = 4'b1011;
    m_ovl = 1'b1;
  endtask

  task automatic test_overlap();
    logic [6:0] stream;
    logic [3:0] held;
    stream = 7'b1011011;
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1 || cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL run_flags: got busy=%b rdy=%b, required 1 0", busy, cfg_ready);
    end
    for (int i = 6; i >= 0; i--) do_sample(stream[i], DIV - 1);
    n_cmp++;
    if (match_count !== 8'd2) begin
      n_bad++;
      $display("FAIL overlap_count: got %0d, required 2", match_count);
    end
    held = out_light;
    pulse_stop();
    n_cmp++;
    if (busy !== 1'b0 || success_light !== 1'b0 || out_light !== held || match_count !== 8'd2) begin
      n_bad++;
      $display("FAIL stop_hold: got busy=%b succ=%b win=%b cnt=%0d, required 0 0 %b 2",
               busy, success_light, out_light, match_count, held);
    end
  endtask

  task automatic test_nonoverlap();
    logic [6:0] stream;
    stream = 7'b1011011;
    cfg_valid = 1'b1; cfg_pattern = 4'b1011; cfg_overlap = 1'b0;
    @(negedge clk_main);
    cfg_valid = 1'b0;
    m_pat = 4'b1011; m_ovl = 1'b0;
    pulse_start();
    for (int i = 6; i >= 0; i--) do_sample(stream[i], DIV - 1);
    n_cmp++;
    if (match_count !== 8'd1) begin
      n_bad++;
      $display("FAIL nonoverlap_count: got %0d, required 1", match_count);
    end
    pulse_stop();
  endtask

  task automatic test_cfg_gating();
    logic [3:0] stream;
    cfg_valid = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
    n_cmp++;
    if (cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL cfg_ready_idle: got %b, required 1", cfg_ready);
    end
    @(negedge clk_main);
    cfg_valid = 1'b0;
    m_pat = 4'b0110; m_ovl = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) do_sample(1'b1, DIV - 1);
    cfg_valid = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b0;
    @(negedge clk_main);
    n_cmp++;
    if (cfg_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL cfg_ready_run: got %b, required 0", cfg_ready);
    end
    @(negedge clk_main);
    cfg_valid = 1'b0;
    do_sample(1'b1, DIV - 3);
    stream = 4'b0110;
    for (int i = 3; i >= 0; i--) do_sample(stream[i], DIV - 1);
    n_cmp++;
    if (match_count !== 8'd1) begin
      n_bad++;
      $display("FAIL gating_count: got %0d, required 1", match_count);
    end
    pulse_stop();
  endtask

  task automatic test_saturation();
    cfg_valid = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    m_pat = 4'b1111; m_ovl = 1'b1;
    pulse_start();
    cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) do_sample(1'b1, DIV - 1);
    n_cmp++;
    if (s_match_count !== 2'd3 || match_count !== 8'd5) begin
      n_bad++;
      $display("FAIL saturation: got sat=%0d wide=%0d, required 3 5", s_match_count, match_count);
    end
  endtask

  task automatic test_stop_on_tick();
    int n;
    n = 0;
    while (sample_tick !== 1'b1 && n < 10) begin
      @(negedge clk_main);
      n++;
    end
    data_in = 1'b0;
    pulse_stop();
    n_cmp++;
    if (busy !== 1'b0 || out_light !== m_win || success_light !== 1'b0 ||
        match_count !== 8'(m_cnt) || s_match_count !== 2'(m_cnt_s)) begin
      n_bad++;
      $display("FAIL stop_on_tick: got busy=%b win=%b succ=%b cnt=%0d, required 0 %b 0 %0d",
               busy, out_light, success_light, match_count, m_win, m_cnt);
    end
  endtask

  task automatic test_rst_midrun();
    logic [6:0] stream;
    pulse_start();
    for (int i = 0; i < 4; i++) do_sample(1'b1, DIV - 1);
    @(negedge clk_main);
    rst = 1'b1;
    @(negedge clk_main);
    rst = 1'b0;
    n_cmp++;
    if (out_light !== 4'd0 || success_light !== 1'b0 || match_count !== 8'd0 ||
        sample_tick !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_midrun: got win=%b succ=%b cnt=%0d tick=%b busy=%b rdy=%b, required 0000 0 0 0 0 1",
               out_light, success_light, match_count, sample_tick, busy, cfg_ready);
    end
    m_pat = 4'b1011; m_ovl = 1'b1;
    stream = 7'b1011011;
    pulse_start();
    for (int i = 6; i >= 0; i--) do_sample(stream[i], DIV - 1);
    n_cmp++;
    if (match_count !== 8'd2) begin
      n_bad++;
      $display("FAIL rst_pattern_count: got %0d, required 2", match_count);
    end
    pulse_stop();
  endtask

  task automatic test_start_stop_idle();
    int ticks;
    start = 1'b1; stop = 1'b1;
    @(negedge clk_main);
    start = 1'b0; stop = 1'b0;
    ticks = 0;
    repeat (2 * DIV) begin
      if (sample_tick !== 1'b0) ticks++;
      @(negedge clk_main);
    end
    n_cmp++;
    if (busy !== 1'b0 || ticks != 0) begin
      n_bad++;
      $display("FAIL start_stop_idle: got busy=%b ticks=%0d, required 0 0", busy, ticks);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_cfg_gating();
    test_saturation();
    test_stop_on_tick();
    test_rst_midrun();
    test_start_stop_idle();
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ssc_seq_ctrl.md
Name: ssc_seq_ctrl

Overview:
- Sequencing controller for the board's serial sequence checker datapath.
- Generates the sample tick from clk_main and shifts data_in into a PAT_W-bit window on each tick.
- Compares the window against a runtime-programmable pattern, in overlapping or non-overlapping mode.
- Provides start/stop run control, a config handshake, LED outputs (window, success) and a saturating match counter.

Parameters:
- DIV, 100_000_000: clk_main cycles per sample tick (must be ≥ 2).
- PAT_W, 4: pattern and window width.
- CNT_W, 8: match counter width.
- RST_PAT, 4'b1011: pattern loaded at reset.

Ports:
- clk_main  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE.
- stop  in  1  one-cycle pulse; ends a run.
- cfg_valid  in  1  config request.
- cfg_pattern  in  PAT_W  pattern to load.
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_ready  out  1  config accepted when cfg_valid & cfg_ready.
- data_in  in  1  serial data, sampled on tick.
- sample_tick  out  1  one-cycle pulse every DIV cycles while running.
- out_light  out  PAT_W  current window, newest bit in [0].
- success_light  out  1  match indicator.
- match_count  out  CNT_W  saturating match count.
- busy  out  1  high in FILL or RUN.

Behaviour:
- Clock and reset: one clock, clk_main. rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - out_light = 0, success_light = 0, match_count = 0, sample_tick = 0, busy = 0.
  - Divider count = 0, fill count = 0.
  - Pattern = RST_PAT, overlap = 1, cfg_ready = 1.
  - rst asserted mid-run overrides everything and gives the reset values on the next edge.
- Divider:
  - Counts 0..DIV-1 only in FILL or RUN.
  - sample_tick = 1 for exactly the cycle in which the count equals DIV-1; the count then wraps to 0.
  - Forced to 0 in IDLE, so the first tick of a run occurs DIV cycles after start is accepted.
- Config:
  - cfg_ready = (state == IDLE).
  - On cfg_valid & cfg_ready, pattern and overlap latch at that edge.
  - cfg_valid outside IDLE is ignored and has no effect.
- FSM states: IDLE, FILL, RUN.
  - IDLE → FILL on start. At that edge: clear out_light, match_count, success_light, fill count and divider.
  - FILL:
    - On each tick, shift and increment the fill count.
    - When the fill count reaches PAT_W (the tick that shifts in the PAT_W-th sample), go to RUN and evaluate the match on that same tick.
  - RUN: on each tick, shift and evaluate.
  - FILL/RUN → IDLE on stop. out_light and match_count hold their values. success_light clears.
- Shift: at a tick edge, out_light <= {out_light[PAT_W-2:0], data_in}.
- Match evaluation:
  - A match occurs when the post-shift window equals the pattern and the window is full.
  - success_light is registered at that same tick edge.
  - It stays high until the next tick edge, i.e. for DIV cycles, one sample period.
  - On a match, match_count increments by 1 and saturates at 2^CNT_W-1.
  - Overlap = 1: remain in RUN.
  - Overlap = 0: go to FILL with fill count = 0. The window bits are kept, but no match is possible until PAT_W new samples have been taken.
- Simultaneous events:
  - stop and tick in the same cycle: stop wins; no shift, no match.
  - start while not in IDLE: ignored.
  - start and cfg_valid in the same IDLE cycle: config latches, and the run uses the new config.
  - start and stop in the same cycle in IDLE: stay in IDLE.
- busy = (state != IDLE).
- Latency: a data_in value present in a tick cycle appears on out_light and success_light one clk_main cycle later.

Decomposition:
- Package ssc_pkg holds:
  - the state enum (IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2);
  - the default constants RST_PAT and DIV.
- One sub-module, ssc_tick_gen: the DIV counter with an enable and a synchronous clear, producing sample_tick.
- FSM, window register and counter stay in ssc_seq_ctrl.

Test Plan:
- All scenarios use DIV = 4.
- Reset: assert rst 2 cycles → all outputs 0, cfg_ready = 1, pattern 1011, overlap 1, and no sample_tick for 20 idle cycles.
- Overlap: start, then drive data_in 1,0,1,1,0,1,1 on successive ticks → success_light high after samples 4 and 7, each for 4 cycles, and match_count = 2.
- Non-overlap: load cfg_pattern = 1011, cfg_overlap = 0, same stream → single match at sample 4, none at sample 7, match_count = 1, FILL re-entered after the match.
- Config gating:
  - Load 0110 in IDLE, start, assert cfg_valid with 1111 during RUN → cfg_ready = 0 and the pattern stays 0110.
  - Stream 0,1,1,0 → match.
- Saturation: CNT_W = 2, overlap stream 1,1,1,1,1,1,1,1 with pattern 1111 → matches on samples 4–8, match_count sticks at 3.
- Stop and rst mid-run:
  - Stop coincident with a tick → no shift, IDLE next cycle, out_light and match_count held.
  - rst mid-RUN → reset values on the next edge.
